// File: rtl/conv_ctrl.sv
// Convolution address sequencer: walks r, c, m, n over an N x N input with an F x F filter and
// caps unacknowledged windows. Optional stall counter is enabled with macro CONV_CTRL_PERF_EN.
module conv_ctrl #(
  parameter int unsigned MAX_OUTST = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  input_size,
  input  logic [7:0]  filter_size,
  output logic        mac_valid,
  input  logic        mac_ready,
  output logic [15:0] in_addr,
  output logic [7:0]  flt_addr,
  output logic        mac_first,
  output logic        mac_last,
  output logic [15:0] out_addr,
  input  logic        acc_ack,
  output logic        busy,
  output logic        done,
  output logic        err
`ifdef CONV_CTRL_PERF_EN
  ,
  output logic [31:0] perf_stall
`endif
);

  typedef enum logic [2:0] {StIdle, StCheck, StRun, StDrain, StFinish} state_e;

  localparam logic [3:0] MaxOutst = 4'(MAX_OUTST);

  state_e     state_q, state_d;
  logic [7:0] n_q, n_d, f_q, f_d;
  logic [7:0] win_r_q, win_r_d, win_c_q, win_c_d;
  logic [7:0] flt_m_q, flt_m_d, flt_n_q, flt_n_d;
  logic [3:0] outst_q, outst_d;
  logic       err_q, err_d;

  logic [7:0]  o_size, o_last, f_last;
  logic [15:0] row_sum;
  logic        at_first, at_last, limited, xfer, final_op, inc, dec;

  assign o_size   = n_q - f_q + 8'd1;
  assign o_last   = o_size - 8'd1;
  assign f_last   = f_q - 8'd1;
  assign at_first = (flt_m_q == 8'd0) && (flt_n_q == 8'd0);
  assign at_last  = (flt_m_q == f_last) && (flt_n_q == f_last);
  // A new window may not start while the accumulator side is full.
  assign limited  = (state_q == StRun) && at_first && (outst_q == MaxOutst);
  assign xfer     = mac_valid && mac_ready;
  assign final_op = at_last && (win_r_q == o_last) && (win_c_q == o_last);
  assign inc      = xfer && at_last;
  assign dec      = acc_ack && (outst_q != 4'd0);

  assign row_sum   = 16'(win_r_q) + 16'(flt_m_q);
  assign in_addr   = row_sum * 16'(n_q) + 16'(win_c_q) + 16'(flt_n_q);
  assign flt_addr  = flt_m_q * f_q + flt_n_q;
  assign out_addr  = 16'(win_r_q) * 16'(o_size) + 16'(win_c_q);
  assign mac_valid = (state_q == StRun) && !limited;
  assign mac_first = (state_q == StRun) && at_first;
  assign mac_last  = (state_q == StRun) && at_last;
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StFinish);
  assign err       = done && err_q;

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    f_d     = f_q;
    win_r_d = win_r_q;
    win_c_d = win_c_q;
    flt_m_d = flt_m_q;
    flt_n_d = flt_n_q;
    err_d   = err_q;
    outst_d = outst_q;
    if (inc && !dec) begin
      outst_d = outst_q + 4'd1;
    end else if (dec && !inc) begin
      outst_d = outst_q - 4'd1;
    end
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StCheck;
          n_d     = input_size;
          f_d     = filter_size;
          err_d   = 1'b0;
        end
      end
      StCheck: begin
        win_r_d = 8'd0;
        win_c_d = 8'd0;
        flt_m_d = 8'd0;
        flt_n_d = 8'd0;
        if ((f_q == 8'd0) || (f_q > 8'd16) || (f_q > n_q)) begin
          err_d   = 1'b1;
          state_d = StFinish;
        end else begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (xfer) begin
          if (flt_n_q != f_last) begin
            flt_n_d = flt_n_q + 8'd1;
          end else begin
            flt_n_d = 8'd0;
            if (flt_m_q != f_last) begin
              flt_m_d = flt_m_q + 8'd1;
            end else begin
              flt_m_d = 8'd0;
              if (win_c_q != o_last) begin
                win_c_d = win_c_q + 8'd1;
              end else begin
                win_c_d = 8'd0;
                win_r_d = (win_r_q == o_last) ? 8'd0 : win_r_q + 8'd1;
              end
            end
          end
          if (final_op) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (outst_q == 4'd0) begin
          state_d = StFinish;
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      n_q     <= 8'd0;
      f_q     <= 8'd0;
      win_r_q <= 8'd0;
      win_c_q <= 8'd0;
      flt_m_q <= 8'd0;
      flt_n_q <= 8'd0;
      outst_q <= 4'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      f_q     <= f_d;
      win_r_q <= win_r_d;
      win_c_q <= win_c_d;
      flt_m_q <= flt_m_d;
      flt_n_q <= flt_n_d;
      outst_q <= outst_d;
      err_q   <= err_d;
    end
  end

`ifdef CONV_CTRL_PERF_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if ((state_q == StIdle) && start) begin
      perf_d = 32'd0;
    end else if ((state_q == StRun) && ((mac_valid && !mac_ready) || limited) &&
                 (perf_q != 32'hFFFF_FFFF)) begin
      perf_d = perf_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_q <= 32'd0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_stall = perf_q;
`endif

endmodule

// File: tb/tb_conv_ctrl.sv
// Self-checking bench for conv_ctrl: a queue-based job model predicts every output each cycle,
// with directed jobs pinning literal values and randomized jobs covering the rest.
module tb_conv_ctrl;
  localparam int unsigned MaxOut = 2;

  logic        clk = 1'b0;
  logic        rst_n, start, mac_valid, mac_ready, mac_first, mac_last, acc_ack;
  logic        busy, done, err;
  logic [7:0]  input_size, filter_size, flt_addr;
  logic [15:0] in_addr, out_addr;
`ifdef CONV_CTRL_PERF_EN
  logic [31:0] perf_stall;
`endif

  always #5 clk = ~clk;

  conv_ctrl #(.MAX_OUTST(MaxOut)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .input_size  (input_size),
    .filter_size (filter_size),
    .mac_valid   (mac_valid),
    .mac_ready   (mac_ready),
    .in_addr     (in_addr),
    .flt_addr    (flt_addr),
    .mac_first   (mac_first),
    .mac_last    (mac_last),
    .out_addr    (out_addr),
    .acc_ack     (acc_ack),
    .busy        (busy),
    .done        (done),
`ifdef CONV_CTRL_PERF_EN
    .err         (err),
    .perf_stall  (perf_stall)
`else
    .err         (err)
`endif
  );

  typedef struct {
    int ia;
    int fa;
    bit first;
    bit last;
    int oa;
  } op_t;

  int  checks = 0;
  int  failures = 0;

  // Model state: 0 idle, 1 check, 2 run, 3 drain, 4 finish.
  int  m_phase = 0;
  int  m_outst = 0;
  bit  m_err = 0;
  int  mn, mf, cyc = 0, acc_cyc = 0;
  op_t mq[$];
  bit  lim, ev, xf, inc, dec;
  int  outst_old;
  longint m_perf = 0;

  op_t log_q[$];
  int  done_cnt = 0, err_cnt = 0, done_cyc = 0;
  longint perf_done = 0;

  int  rdy_mode = 0;
  bit  ack_hold = 0, ack_spur = 0, ack_force = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d time=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit exp_valid();
    return (m_phase == 2) && (mq.size() > 0) &&
           !(mq[0].first && (m_outst == int'(MaxOut)));
  endfunction

  // Behavioural model: the job is a precomputed list of operations consumed on handshakes.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_phase = 0;
        mq.delete();
        m_outst = 0;
        m_err = 0;
      end else begin
        cyc++;
        lim = (m_phase == 2) && (mq.size() > 0) && mq[0].first && (m_outst == int'(MaxOut));
        ev  = exp_valid();
        xf  = ev && mac_ready;
        inc = xf && mq[0].last;
        dec = acc_ack && (m_outst > 0);
        outst_old = m_outst;
        m_outst = m_outst + (inc ? 1 : 0) - (dec ? 1 : 0);
        case (m_phase)
          0: if (start) begin
            mn = int'(input_size);
            mf = int'(filter_size);
            m_phase = 1;
            m_err = 0;
            m_perf = 0;
            acc_cyc = cyc;
          end
          1: begin
            if (mf == 0 || mf > 16 || mf > mn) begin
              m_err = 1;
              m_phase = 4;
            end else begin
              for (int r = 0; r < mn - mf + 1; r++)
                for (int c = 0; c < mn - mf + 1; c++)
                  for (int m = 0; m < mf; m++)
                    for (int n = 0; n < mf; n++) begin
                      op_t o;
                      o.ia = (r + m) * mn + (c + n);
                      o.fa = m * mf + n;
                      o.first = (m == 0 && n == 0);
                      o.last = (m == mf - 1 && n == mf - 1);
                      o.oa = r * (mn - mf + 1) + c;
                      mq.push_back(o);
                    end
              m_phase = 2;
            end
          end
          2: begin
            if ((lim || (ev && !mac_ready)) && m_perf != 64'hFFFF_FFFF) m_perf++;
            if (xf) begin
              void'(mq.pop_front());
              if (mq.size() == 0) m_phase = 3;
            end
          end
          3: if (outst_old == 0) m_phase = 4;
          default: begin
            m_phase = 0;
            m_err = 0;
          end
        endcase
      end
    end
  end

  // Compare process, sampling half a cycle after the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("reset_outputs", longint'({mac_valid, in_addr, flt_addr, mac_first, mac_last,
                                        out_addr, busy, done, err}), 0);
      end else begin
        chk("mac_valid", longint'(mac_valid), longint'(exp_valid()));
        chk("busy", longint'(busy), longint'(m_phase != 0));
        chk("done", longint'(done), longint'(m_phase == 4));
        chk("err", longint'(err), longint'(m_phase == 4 && m_err));
        if (mac_valid && exp_valid()) begin
          chk("in_addr", longint'(in_addr), longint'(mq[0].ia));
          chk("flt_addr", longint'(flt_addr), longint'(mq[0].fa));
          chk("mac_first", longint'(mac_first), longint'(mq[0].first));
          chk("mac_last", longint'(mac_last), longint'(mq[0].last));
          if (mq[0].last) chk("out_addr", longint'(out_addr), longint'(mq[0].oa));
        end
        if (mac_valid && mac_ready) begin
          op_t o;
          o.ia = int'(in_addr);
          o.fa = int'(flt_addr);
          o.first = mac_first;
          o.last = mac_last;
          o.oa = int'(out_addr);
          log_q.push_back(o);
        end
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        if (err) err_cnt++;
`ifdef CONV_CTRL_PERF_EN
        chk("perf_stall", longint'(perf_stall), m_perf);
        if (done) perf_done = longint'(perf_stall);
`endif
      end
    end
  end

  // Handshake driver for mac_ready and acc_ack.
  initial begin
    mac_ready = 1'b0;
    acc_ack = 1'b0;
    forever begin
      @(posedge clk);
      #3;
      case (rdy_mode)
        0: mac_ready = 1'b1;
        1: mac_ready = ~mac_ready;
        2: mac_ready = 1'($urandom_range(0, 1));
        default: mac_ready = 1'b0;
      endcase
      if (ack_force) begin
        acc_ack = 1'b1;
        ack_force = 1'b0;
      end else if (ack_hold) begin
        acc_ack = 1'b0;
      end else if (m_outst > 0) begin
        acc_ack = ($urandom_range(0, 2) == 0);
      end else begin
        acc_ack = ack_spur && ($urandom_range(0, 5) == 0);
      end
    end
  end

  task automatic start_job(input int n, input int f);
    log_q.delete();
    done_cnt = 0;
    err_cnt = 0;
    @(posedge clk);
    #2;
    start = 1'b1;
    input_size = 8'(n);
    filter_size = 8'(f);
    @(posedge clk);
    #2;
    start = 1'b0;
    input_size = 8'($urandom);
    filter_size = 8'($urandom);
  endtask

  task automatic wait_idle(input bit poke);
    int k = 0;
    while (m_phase != 0 && k < 20000) begin
      @(posedge clk);
      #2;
      k++;
      if (poke) start = ($urandom_range(0, 15) == 0);
    end
    start = 1'b0;
    chk("job_timeout", longint'(k < 20000), 1);
  endtask

  task automatic run_job(input int n, input int f, input bit poke);
    start_job(n, f);
    wait_idle(poke);
  endtask

  initial begin
    int w0_ia[4] = '{0, 1, 3, 4};
    int w3_ia[4] = '{7, 8, 10, 11};
    int bad_n[4] = '{4, 4, 4, 20};
    int bad_f[4] = '{5, 0, 17, 17};
    int k;
    rst_n = 1'b0;
    start = 1'b0;
    input_size = 8'd0;
    filter_size = 8'd0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    chk("idle_busy", longint'(busy), 0);

    // N=3, F=2: four windows of four terms.
    rdy_mode = 0;
    run_job(3, 2, 0);
    chk("w_ops", log_q.size(), 16);
    chk("w_done", done_cnt, 1);
    chk("w_err", err_cnt, 0);
    if (log_q.size() == 16) begin
      for (int i = 0; i < 4; i++) begin
        chk("w0_in_addr", log_q[i].ia, w0_ia[i]);
        chk("w0_flt_addr", log_q[i].fa, i);
        chk("w3_in_addr", log_q[12 + i].ia, w3_ia[i] - 3);
      end
      chk("w0_first", log_q[0].first, 1);
      chk("w0_last", log_q[3].last, 1);
      chk("w3_out_addr", log_q[15].oa, 3);
    end

    // Illegal filters end with done+err two cycles after the start cycle.
    for (int i = 0; i < 4; i++) begin
      run_job(bad_n[i], bad_f[i], 0);
      chk("bad_ops", log_q.size(), 0);
      chk("bad_done", done_cnt, 1);
      chk("bad_err", err_cnt, 1);
      chk("bad_latency", done_cyc - acc_cyc, 1);
    end

    // Largest legal filter.
    run_job(16, 16, 0);
    chk("f16_ops", log_q.size(), 256);
    chk("f16_err", err_cnt, 0);

    // F=1 with alternating backpressure.
    rdy_mode = 1;
    run_job(3, 1, 0);
    chk("f1_ops", log_q.size(), 9);
    if (log_q.size() == 9)
      for (int i = 0; i < 9; i++) chk("f1_in_addr", log_q[i].ia, i);

    // Outstanding limit with acknowledgements withheld.
    rdy_mode = 0;
    ack_hold = 1;
    start_job(4, 2);
    repeat (40) @(posedge clk);
    #2;
    chk("lim_ops", log_q.size(), 8);
    chk("lim_valid", longint'(mac_valid), 0);
    chk("lim_model_outst", m_outst, 2);
    ack_force = 1;
    repeat (20) @(posedge clk);
    #2;
    chk("lim_ops_after_ack", log_q.size(), 12);
    ack_hold = 0;
    wait_idle(0);
    chk("lim_total_ops", log_q.size(), 36);
    chk("lim_done", done_cnt, 1);

    // Reset while op 5 is offered abandons the job.
    start_job(5, 3);
    k = 0;
    while (log_q.size() < 5 && k < 100) begin
      @(posedge clk);
      #2;
      k++;
    end
    chk("rst_reach_op5", longint'(log_q.size()), 5);
    rst_n = 1'b0;
    #1;
    chk("rst_async_valid", longint'(mac_valid), 0);
    chk("rst_async_busy", longint'(busy), 0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    chk("rst_no_done", done_cnt, 0);
    run_job(5, 3, 0);
    chk("rst_fresh_ops", log_q.size(), 81);
    chk("rst_fresh_done", done_cnt, 1);

`ifdef CONV_CTRL_PERF_EN
    rdy_mode = 3;
    start_job(2, 2);
    k = 0;
    while (m_phase != 2 && k < 10) begin
      @(posedge clk);
      #2;
      k++;
    end
    repeat (3) begin
      @(posedge clk);
      #2;
    end
    rdy_mode = 0;
    wait_idle(0);
    chk("perf_ops", log_q.size(), 4);
    chk("perf_at_done", perf_done, 3);
`endif

    // Randomized jobs with random backpressure, stray starts and spurious acks.
    for (int j = 0; j < 25; j++) begin
      int n, f, o, exp_ops;
      n = $urandom_range(1, 8);
      f = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 20) : $urandom_range(1, n);
      o = n - f + 1;
      exp_ops = (f == 0 || f > 16 || f > n) ? 0 : o * o * f * f;
      rdy_mode = $urandom_range(0, 2);
      ack_spur = 1'($urandom_range(0, 1));
      run_job(n, f, 1);
      chk("rnd_ops", log_q.size(), exp_ops);
      chk("rnd_done", done_cnt, 1);
      chk("rnd_err", err_cnt, (exp_ops == 0) ? 1 : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
